// File: rtl/ad_sample_capture_if.sv
// Signal bundle between the capture block and its surroundings: the ADC
// data bus, trigger controls, status flags and the RAM readout port.
interface ad_sample_capture_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10
);
    logic              ad_clk;
    logic [DATA_W-1:0] ad_data;
    logic              ad_otr;
    logic              start;
    logic [DATA_W-1:0] trig_level;
    logic              trig_edge;
    logic              trig_auto;
    logic              busy;
    logic              done;
    logic              otr_seen;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    // host / ADC side
    modport master (
        output ad_data, ad_otr, start, trig_level, trig_edge, trig_auto, rd_addr,
        input  ad_clk, busy, done, otr_seen, rd_data
    );

    // capture block side
    modport slave (
        input  ad_data, ad_otr, start, trig_level, trig_edge, trig_auto, rd_addr,
        output ad_clk, busy, done, otr_seen, rd_data
    );
endinterface

// File: rtl/ad_sample_capture.sv
// One-shot ADC capture: divides sys_clk into the ADC sample clock, registers
// each sample, waits for a level crossing (or auto trigger) and stores DEPTH
// consecutive samples in a RAM readable with one cycle of latency.
module ad_sample_capture #(
    parameter int DATA_W  = 12,
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 1024,
    parameter int CLK_DIV = 4
) (
    input  logic               sys_clk,
    input  logic               rst,
    ad_sample_capture_if.slave bus
);
    localparam int CNT_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              ad_clk_q;
    logic              s_en;
    logic              new_smp;
    logic [DATA_W-1:0] cur, prev;
    logic              otr_q;
    logic              prev_valid;
    logic              otr_seen_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] rd_q;
    logic              arm, we, load_prev, hit;
    logic [DATA_W-1:0] mem [DEPTH];

    // Strobe on the last divider count: the same edge that raises ad_clk.
    assign s_en = (cnt == CNT_W'(CLK_DIV - 1));

    // Clock divider: ad_clk high for the first half of each period.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt      <= '0;
            ad_clk_q <= 1'b0;
        end else begin
            cnt <= s_en ? '0 : cnt + CNT_W'(1);
            if (s_en)
                ad_clk_q <= 1'b1;
            else if (cnt == CNT_W'(CLK_DIV / 2 - 1))
                ad_clk_q <= 1'b0;
        end
    end

    // Sample register; new_smp marks the cycle the capture logic consumes it.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cur     <= '0;
            otr_q   <= 1'b0;
            new_smp <= 1'b0;
        end else begin
            new_smp <= s_en;
            if (s_en) begin
                cur   <= bus.ad_data;
                otr_q <= bus.ad_otr;
            end
        end
    end

    // Trigger decision for the current sample against the previous one.
    always_comb begin
        hit = 1'b0;
        if (bus.trig_auto)
            hit = 1'b1;
        else if (prev_valid) begin
            if (bus.trig_edge)
                hit = (prev > bus.trig_level) && (cur <= bus.trig_level);
            else
                hit = (prev < bus.trig_level) && (cur >= bus.trig_level);
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FSM next state and per-cycle control strobes.
    always_comb begin
        state_nx  = state;
        arm       = 1'b0;
        we        = 1'b0;
        load_prev = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    arm      = 1'b1;
                    state_nx = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                if (new_smp) begin
                    if (hit) begin
                        we       = 1'b1;
                        state_nx = CAPTURE;
                    end else begin
                        load_prev = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (new_smp) begin
                    we = 1'b1;
                    if (wr_ptr == ADDR_W'(DEPTH - 1))
                        state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture bookkeeping: write pointer, previous sample, sticky range flag.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            otr_seen_q <= 1'b0;
        end else if (arm) begin
            wr_ptr     <= '0;
            prev_valid <= 1'b0;
            otr_seen_q <= 1'b0;
        end else begin
            if (load_prev) begin
                prev       <= cur;
                prev_valid <= 1'b1;
            end
            if (we) begin
                otr_seen_q <= otr_seen_q | otr_q;
                // Pointer parks on the last word instead of wrapping.
                if (wr_ptr != ADDR_W'(DEPTH - 1))
                    wr_ptr <= wr_ptr + ADDR_W'(1);
            end
        end
    end

    // Capture RAM write port; a reset cycle never writes.
    always_ff @(posedge sys_clk) begin
        if (we && !rst)
            mem[wr_ptr] <= cur;
    end

    // Registered read port, read-first against a same-cycle write.
    always_ff @(posedge sys_clk) begin
        if (rst) rd_q <= '0;
        else     rd_q <= mem[bus.rd_addr];
    end

    assign bus.ad_clk   = ad_clk_q;
    assign bus.busy     = (state == WAIT_TRIG) || (state == CAPTURE);
    assign bus.done     = (state == DONE);
    assign bus.otr_seen = otr_seen_q;
    assign bus.rd_data  = rd_q;
endmodule

// File: tb/tb_ad_sample_capture.sv
// Bench for ad_sample_capture: drives a sample stream from an array, one value
// per ad_clk period, and predicts trigger position, RAM contents, done timing
// and the sticky range flag directly from that stream.
module tb_ad_sample_capture;
    localparam int DW    = 12;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int NS    = 65536;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;

    ad_sample_capture_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ad_sample_capture #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .CLK_DIV(4)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    int smp [NS];
    bit otr [NS];
    int pi    = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // ADC model: a new value appears shortly after each falling ad_clk edge.
    initial begin
        forever begin
            @(negedge bus.ad_clk);
            #2;
            bus.ad_data = DW'(smp[pi % NS]);
            bus.ad_otr  = otr[pi % NS];
            pi++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Align to the cycle just after an ad_clk rise, where the stream index is stable.
    task automatic sync_phase();
        logic last;
        last = bus.ad_clk;
        for (int c = 0; c < 16; c++) begin
            @(posedge sys_clk); #1;
            if (bus.ad_clk === 1'b1 && last === 1'b0) break;
            last = bus.ad_clk;
        end
        @(posedge sys_clk); #1;
    endtask

    task automatic fill_ramp(input int base, input int v0);
        for (int i = 0; i < 6000; i++) begin
            smp[base + i] = (v0 + i) % 4096;
            otr[base + i] = 1'b0;
        end
    endtask

    task automatic fill_rand(input int base, input int otr_mod);
        for (int i = 0; i < 6000; i++) begin
            smp[base + i] = int'($urandom_range(0, 4095));
            otr[base + i] = (otr_mod > 0) ? ($urandom_range(0, otr_mod - 1) == 0) : 1'b0;
        end
    endtask

    // Reference: index of the stream sample that becomes mem[0].
    task automatic find_trig(input int j, input bit aut, input bit edg, input int lvl, output int t);
        t = -1;
        if (aut) t = j;
        else begin
            for (int k = j + 1; k < NS; k++) begin
                if (edg ? (smp[k-1] > lvl && smp[k] <= lvl) : (smp[k-1] < lvl && smp[k] >= lvl)) begin
                    t = k;
                    break;
                end
            end
        end
        if (t < 0 || t + DEPTH + 6000 >= NS) begin
            $display("FAIL model: no trigger found in stream");
            $fatal(1);
        end
    endtask

    task automatic pulse_start(input string tag);
        bus.start = 1'b1;
        @(posedge sys_clk); #1;
        bus.start = 1'b0;
        chk({tag, " busy_after_arm"}, bus.busy, 1);
        chk({tag, " done_after_arm"}, bus.done, 0);
        chk({tag, " otr_clear_after_arm"}, bus.otr_seen, 0);
    endtask

    task automatic arm(input string tag, input bit aut, input bit edg, input int lvl, input int t_in, output int t);
        bus.trig_auto  = aut;
        bus.trig_edge  = edg;
        bus.trig_level = DW'(lvl);
        find_trig(t_in, aut, edg, lvl, t);
        pulse_start(tag);
    endtask

    task automatic wait_pi(input int target);
        for (int c = 0; c < 40000; c++) begin
            if (pi >= target) break;
            @(posedge sys_clk); #1;
        end
    endtask

    // Wait for done, then check timing, full RAM contents and the range flag.
    task automatic finish_capture(input string tag, input int t, output logic [31:0] w0);
        bit   ok;
        bit   dropped;
        int   bad;
        bit   exp_otr;
        ok = 1'b0; dropped = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge sys_clk); #1;
            if (bus.done === 1'b1) begin ok = 1'b1; break; end
            if (bus.busy !== 1'b1) dropped = 1'b1;
        end
        chk({tag, " done_seen"}, ok, 1);
        chk({tag, " busy_until_done"}, dropped, 0);
        chk({tag, " done_sample_count"}, pi, t + DEPTH);
        chk({tag, " busy_in_done"}, bus.busy, 0);
        bad = 0;
        w0  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.rd_addr = AW'(i);
            @(posedge sys_clk); #1;
            if (i == 0) w0 = 32'(bus.rd_data);
            if (bus.rd_data !== DW'(smp[t + i])) bad++;
        end
        chk({tag, " mem_bad_words"}, bad, 0);
        chk({tag, " mem0"}, w0, smp[t]);
        exp_otr = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_otr |= otr[t + i];
        chk({tag, " otr_seen"}, bus.otr_seen, exp_otr);
        chk({tag, " done_holds"}, bus.done, 1);
    endtask

    initial begin
        int j, t;
        logic [31:0] w0;
        bus.start = 1'b0; bus.trig_level = '0; bus.trig_edge = 1'b0; bus.trig_auto = 1'b0;
        bus.rd_addr = '0; bus.ad_data = '0; bus.ad_otr = 1'b0;

        // reset state and divider waveform
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst ad_clk", bus.ad_clk, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst done", bus.done, 0);
        chk("rst otr_seen", bus.otr_seen, 0);
        chk("rst rd_data", bus.rd_data, 0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("div ad_clk k=%0d", k), bus.ad_clk, (k >= 4) && ((k - 4) % 4 < 2));
            @(posedge sys_clk); #1;
        end

        // ramp through a rising threshold
        sync_phase(); j = pi; fill_ramp(j, 0);
        arm("ramp", 1'b0, 1'b0, 2048, j, t);
        finish_capture("ramp", t, w0);
        chk("ramp mem0_const", w0, 2048);

        // falling crossing landing exactly on the level
        sync_phase(); j = pi; fill_rand(j, 0);
        smp[j] = 3000; smp[j+1] = 2100; smp[j+2] = 2048; smp[j+3] = 1000;
        arm("fall", 1'b0, 1'b1, 2048, j, t);
        finish_capture("fall", t, w0);
        chk("fall mem0_const", w0, 2048);

        // auto trigger on a constant input
        sync_phase(); j = pi;
        for (int i = 0; i < 6000; i++) begin smp[j+i] = 777; otr[j+i] = 1'b0; end
        arm("auto", 1'b1, 1'b0, int'($urandom_range(0, 4095)), j, t);
        finish_capture("auto", t, w0);
        chk("auto mem0_const", w0, 777);

        // out-of-range only outside the stored window
        sync_phase(); j = pi; fill_ramp(j, 2000);
        for (int i = 0; i < 48; i++) otr[j+i] = 1'b1;
        for (int i = 0; i < 80; i++) otr[j + 48 + DEPTH + i] = 1'b1;
        arm("otr_out", 1'b0, 1'b0, 2048, j, t);
        finish_capture("otr_out", t, w0);
        chk("otr_out flag_const", bus.otr_seen, 0);

        // single out-of-range pulse on captured sample 10
        sync_phase(); j = pi; fill_ramp(j, 2000);
        arm("otr_in", 1'b0, 1'b0, 2048, j, t);
        otr[t + 10] = 1'b1;
        finish_capture("otr_in", t, w0);
        chk("otr_in flag_const", bus.otr_seen, 1);

        // start pulse while capturing is ignored
        sync_phase(); j = pi; fill_rand(j, 0);
        arm("restart", 1'b0, 1'b0, int'($urandom_range(300, 3800)), j, t);
        wait_pi(t + 100);
        bus.start = 1'b1;
        @(posedge sys_clk); #1;
        bus.start = 1'b0;
        chk("restart busy_kept", bus.busy, 1);
        finish_capture("restart", t, w0);

        // reset in the middle of a capture
        sync_phase(); j = pi; fill_ramp(j, 2040);
        arm("midrst", 1'b0, 1'b0, 2048, j, t);
        wait_pi(t + 500);
        rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("midrst busy_in_rst", bus.busy, 0);
        rst = 1'b0;
        repeat (20) @(posedge sys_clk);
        #1;
        chk("midrst busy_after", bus.busy, 0);
        chk("midrst done_after", bus.done, 0);

        // re-arm after reset, falling edge on random data
        sync_phase(); j = pi; fill_rand(j, 0);
        arm("rearm", 1'b0, 1'b1, int'($urandom_range(300, 3800)), j, t);
        finish_capture("rearm", t, w0);

        // random streams with sparse out-of-range flags
        for (int r = 0; r < 2; r++) begin
            sync_phase(); j = pi; fill_rand(j, 300);
            arm($sformatf("rand%0d", r), 1'b0, 1'($urandom_range(0, 1)),
                int'($urandom_range(100, 3995)), j, t);
            finish_capture($sformatf("rand%0d", r), t, w0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
